// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with a per-register pending-write scoreboard.
// Two write-back sources share one write port, with round-robin arbitration and hazard detection.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        wb0_valid,
    output logic        wb0_ready,
    input  logic [4:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    input  logic        wb1_valid,
    output logic        wb1_ready,
    input  logic [4:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        hazard1,
    output logic        hazard2
);

    logic [1:0] cnt_r [32];
    logic       last_grant_r;
    logic       grant0_s;
    logic       grant1_s;
    logic       xfer0_s;
    logic       xfer1_s;
    logic       commit_s;
    logic       claim_s;

    function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic inc, input logic dec);
        logic [1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cur + 2'd1;
            2'b01:   nxt = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // An in-flight commit of the last pending write already makes the operand visible.
    function automatic logic hazard_f(input logic [4:0] addr, input logic [1:0] cnt,
                                      input logic we, input logic [4:0] waddr);
        return (addr != 5'd0) && (cnt != 2'd0) && !(we && (waddr == addr) && (cnt == 2'd1));
    endfunction

    // Arbitration, handshakes, claim acceptance and hazard lookup.
    always_comb begin
        grant0_s    = wb0_valid && (!wb1_valid || last_grant_r);
        grant1_s    = wb1_valid && (!wb0_valid || !last_grant_r);
        wb0_ready   = rdy && grant0_s;
        wb1_ready   = rdy && grant1_s;
        xfer0_s     = wb0_valid && wb0_ready;
        xfer1_s     = wb1_valid && wb1_ready;
        commit_s    = rf_we && rdy;
        issue_ready = rdy && ((issue_rd == 5'd0) || (cnt_r[issue_rd] != 2'd3));
        claim_s     = issue_valid && issue_ready && (issue_rd != 5'd0);
        hazard1     = hazard_f(chk_addr1, cnt_r[chk_addr1], rf_we, rf_waddr);
        hazard2     = hazard_f(chk_addr2, cnt_r[chk_addr2], rf_we, rf_waddr);
    end

    // Pending-write counters; entry 0 is held at zero so x0 never reports a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= 2'd0;
            end
        end else if (rdy) begin
            for (int i = 0; i < 32; i++) begin
                if (flush || (i == 0)) begin
                    cnt_r[i] <= 2'd0;
                end else begin
                    cnt_r[i] <= cnt_next(cnt_r[i],
                                         claim_s && (issue_rd == 5'(i)),
                                         commit_s && (rf_waddr == 5'(i)));
                end
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Register-file write port and round-robin history; updates only on a completed transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'd0;
            last_grant_r <= 1'b1;
        end else if (rdy) begin
            if (xfer0_s) begin
                rf_we        <= (wb0_addr != 5'd0);
                rf_waddr     <= wb0_addr;
                rf_wdata     <= wb0_data;
                last_grant_r <= 1'b0;
            end else if (xfer1_s) begin
                rf_we        <= (wb1_addr != 5'd0);
                rf_waddr     <= wb1_addr;
                rf_wdata     <= wb1_data;
                last_grant_r <= 1'b1;
            end else begin
                rf_we        <= 1'b0;
            end
        end else begin
            rf_we        <= rf_we;
            rf_waddr     <= rf_waddr;
            rf_wdata     <= rf_wdata;
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter: each row is one cycle of
// inputs plus the outputs expected in that cycle, followed by a hand-written flush sequence.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        hazard1, hazard2;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, flush, iv;
        logic [4:0]  ird;
        logic        w0v;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1v;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic [4:0]  c1, c2;
        logic        ir, r0, r1, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        h1, h2;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t mk(
        input logic rs, input logic rd, input logic fl, input logic iv, input logic [4:0] ird,
        input logic w0v, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1v, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic [4:0] c1, input logic [4:0] c2,
        input logic ir, input logic r0, input logic r1, input logic we,
        input logic [4:0] wa, input logic [31:0] wd, input logic h1, input logic h2);
        vec_t v;
        v.rst = rs; v.rdy = rd; v.flush = fl; v.iv = iv; v.ird = ird;
        v.w0v = w0v; v.w0a = w0a; v.w0d = w0d;
        v.w1v = w1v; v.w1a = w1a; v.w1d = w1d;
        v.c1 = c1; v.c2 = c2;
        v.ir = ir; v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd; v.h1 = h1; v.h2 = h2;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy; flush = v.flush;
        issue_valid = v.iv; issue_rd = v.ird;
        wb0_valid = v.w0v; wb0_addr = v.w0a; wb0_data = v.w0d;
        wb1_valid = v.w1v; wb1_addr = v.w1a; wb1_data = v.w1d;
        chk_addr1 = v.c1; chk_addr2 = v.c2;
    endtask

    task automatic step(input vec_t v, input int idx);
        apply(v);
        #1;
        chk("issue_ready", idx, 32'(issue_ready), 32'(v.ir));
        chk("wb0_ready",   idx, 32'(wb0_ready),   32'(v.r0));
        chk("wb1_ready",   idx, 32'(wb1_ready),   32'(v.r1));
        chk("rf_we",       idx, 32'(rf_we),       32'(v.we));
        chk("rf_waddr",    idx, 32'(rf_waddr),    32'(v.wa));
        chk("rf_wdata",    idx, rf_wdata,         v.wd);
        chk("hazard1",     idx, 32'(hazard1),     32'(v.h1));
        chk("hazard2",     idx, 32'(hazard2),     32'(v.h2));
    endtask

    initial begin
        //                 rst   rdy   fl    iv    ird    w0v   w0a    w0d            w1v   w1a    w1d           c1     c2      ir    r0    r1    we    wa     wd             h1    h2
        // claim x5, ALU write-back, bypass in commit cycle
        vecs[0]  = mk(1'b0,1'b1,1'b0,1'b1,5'd5, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd5, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd5, 32'hDEADBEEF,  1'b0,5'd0, 32'h0,        5'd5, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,         1'b1,1'b0);
        vecs[2]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd5, 5'd0,  1'b1,1'b0,1'b0,1'b1,5'd5, 32'hDEADBEEF,  1'b0,1'b0);
        vecs[3]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd5, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd5, 32'hDEADBEEF,  1'b0,1'b0);
        // reset with a write handshake in the same cycle: write must be discarded
        vecs[4]  = mk(1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd4, 32'h44444444,  1'b0,5'd0, 32'h0,        5'd5, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd5, 32'hDEADBEEF,  1'b0,1'b0);
        // round-robin: wb0, wb1, wb0
        vecs[5]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd1, 32'h11,        1'b1,5'd2, 32'h22,       5'd1, 5'd2,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0);
        vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd1, 32'h11,        1'b1,5'd2, 32'h22,       5'd1, 5'd2,  1'b1,1'b0,1'b1,1'b1,5'd1, 32'h11,        1'b0,1'b0);
        vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd1, 32'h11,        1'b1,5'd2, 32'h22,       5'd1, 5'd2,  1'b1,1'b1,1'b0,1'b1,5'd2, 32'h22,        1'b0,1'b0);
        vecs[8]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd1, 5'd2,  1'b1,1'b0,1'b0,1'b1,5'd1, 32'h11,        1'b0,1'b0);
        // WAW saturation on x7, then commit frees one slot
        vecs[9]  = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd1, 32'h11,        1'b0,1'b0);
        vecs[10] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd1, 32'h11,        1'b1,1'b0);
        vecs[11] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd1, 32'h11,        1'b1,1'b0);
        vecs[12] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b0,1'b0,1'b0,1'b0,5'd1, 32'h11,        1'b1,1'b0);
        vecs[13] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b1,5'd7, 32'h77,        1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b0,1'b1,1'b0,1'b0,5'd1, 32'h11,        1'b1,1'b0);
        vecs[14] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b0,1'b0,1'b0,1'b1,5'd7, 32'h77,        1'b1,1'b0);
        vecs[15] = mk(1'b0,1'b1,1'b0,1'b0,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd7, 32'h77,        1'b1,1'b0);
        // same-cycle increment and commit decrement on x7 leave count at 2
        vecs[16] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd7, 32'h70,        1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd7, 32'h77,        1'b1,1'b0);
        vecs[17] = mk(1'b0,1'b1,1'b0,1'b1,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b1,5'd7, 32'h70,        1'b1,1'b0);
        vecs[18] = mk(1'b0,1'b1,1'b0,1'b0,5'd7, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd7, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd7, 32'h70,        1'b1,1'b0);
        // rdy low for 3 cycles with a pending write to x9
        vecs[19] = mk(1'b0,1'b1,1'b0,1'b1,5'd9, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd9, 5'd7,  1'b1,1'b0,1'b0,1'b0,5'd7, 32'h70,        1'b0,1'b1);
        vecs[20] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,5'd9, 32'h99,        1'b0,5'd0, 32'h0,        5'd9, 5'd7,  1'b1,1'b1,1'b0,1'b0,5'd7, 32'h70,        1'b1,1'b1);
        vecs[21] = mk(1'b0,1'b0,1'b0,1'b1,5'd9, 1'b1,5'd3, 32'h33,        1'b1,5'd4, 32'h44,       5'd9, 5'd7,  1'b0,1'b0,1'b0,1'b1,5'd9, 32'h99,        1'b0,1'b1);
        vecs[22] = mk(1'b0,1'b0,1'b0,1'b1,5'd9, 1'b1,5'd3, 32'h33,        1'b1,5'd4, 32'h44,       5'd9, 5'd7,  1'b0,1'b0,1'b0,1'b1,5'd9, 32'h99,        1'b0,1'b1);
        vecs[23] = mk(1'b0,1'b0,1'b0,1'b1,5'd9, 1'b1,5'd3, 32'h33,        1'b1,5'd4, 32'h44,       5'd9, 5'd7,  1'b0,1'b0,1'b0,1'b1,5'd9, 32'h99,        1'b0,1'b1);
        vecs[24] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd9, 5'd7,  1'b1,1'b0,1'b0,1'b1,5'd9, 32'h99,        1'b0,1'b1);
        vecs[25] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd9, 5'd7,  1'b1,1'b0,1'b0,1'b0,5'd9, 32'h99,        1'b0,1'b1);
        // write-back to x0 is accepted but never writes
        vecs[26] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b1,5'd0, 32'h1234,     5'd0, 5'd7,  1'b1,1'b0,1'b1,1'b0,5'd9, 32'h99,        1'b0,1'b1);
        vecs[27] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd0, 5'd7,  1'b1,1'b0,1'b0,1'b0,5'd0, 32'h1234,      1'b0,1'b1);
        // flush overrides a same-cycle claim of x3 and clears x7
        vecs[28] = mk(1'b0,1'b1,1'b1,1'b1,5'd3, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd3, 5'd7,  1'b1,1'b0,1'b0,1'b0,5'd0, 32'h1234,      1'b0,1'b1);
        vecs[29] = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,        5'd3, 5'd7,  1'b1,1'b0,1'b0,1'b0,5'd0, 32'h1234,      1'b0,1'b0);

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
        wb0_valid = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
        wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
        chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            step(vecs[i], i);
        end

        // Flush while a commit to a doubly-claimed x10 is in flight: count ends at 0.
        apply(mk(1'b0,1'b1,1'b0,1'b1,5'd10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd10,5'd0, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0));
        apply(mk(1'b0,1'b1,1'b0,1'b1,5'd10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd10,5'd0, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0));
        apply(mk(1'b0,1'b1,1'b0,1'b0,5'd0,  1'b1,5'd10,32'hA0, 1'b0,5'd0,32'h0, 5'd10,5'd0, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0));
        #1;
        chk("seq_wb0_ready", 100, 32'(wb0_ready), 32'd1);
        apply(mk(1'b0,1'b1,1'b1,1'b1,5'd10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd10,5'd0, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0));
        #1;
        chk("seq_hazard_pre",  101, 32'(hazard1),  32'd1);
        chk("seq_rf_we_pre",   101, 32'(rf_we),    32'd1);
        chk("seq_rf_waddr",    101, 32'(rf_waddr), 32'd10);
        chk("seq_rf_wdata",    101, rf_wdata,      32'hA0);
        apply(mk(1'b0,1'b1,1'b0,1'b0,5'd10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd10,5'd0, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0));
        #1;
        chk("seq_hazard_post", 102, 32'(hazard1),     32'd0);
        chk("seq_rf_we_post",  102, 32'(rf_we),       32'd0);
        chk("seq_issue_ready", 102, 32'(issue_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
